multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS-subset core. Sequences the instruction register load, PC update, the shared instruction/data memory port, register-file writes and ALU source selection across fetch, decode, execute, memory and writeback cycles. Sits beside the instruction register and drives its `write_ir` input. Decodes the opcode field `instr_all[31:26]`. Stalls on a memory ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and
// datapath mux select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset core; sequences fetch,
// decode, execute, memory and writeback with a memory ready handshake.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       write_ir,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state;
    state_t state_nxt;

    // zero only qualifies pc_write_cond inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (opcode == OP_LW),
                    (opcode == OP_SW):    state_nxt = S_MEM_ADDR;
                    (opcode == OP_RTYPE): state_nxt = S_R_EXEC;
                    (opcode == OP_BEQ):   state_nxt = S_BRANCH;
                    (opcode == OP_ADDI):  state_nxt = S_ADDI_EXEC;
                    (opcode == OP_J):     state_nxt = S_JUMP;
                    default:              state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WR:    if (mem_ready) state_nxt = S_FETCH;
            S_R_EXEC:    state_nxt = S_R_WB;
            S_R_WB:      state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
            S_ADDI_WB:   state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_ILLEGAL:   state_nxt = S_ILLEGAL;
            default:     state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        write_ir      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR load and PC+4 commit only when the fetch completes
                write_ir  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       write_ir, pc_write, pc_write_cond, i_or_d;
    logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ov;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // {write_ir,pc_write,pc_write_cond,i_or_d,mem_read,mem_write,
    //  mem_to_reg,reg_dst,reg_write,alu_src_a,src_b[2],alu_op[2],pc_src[2],ill}
    localparam logic [16:0] E_ZERO    = 17'd0;
    localparam logic [16:0] E_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_R = 17'b1_1_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_ADDR    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEM_RD  = 17'b0_0_0_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEM_WB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MEM_WR  = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_R_EXEC  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_R_WB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_BRANCH  = 17'b0_0_1_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_ADDI_WB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] E_JUMP    = 17'b0_1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] E_ILL     = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    logic [16:0] act_ov;
    assign act_ov = {write_ir, pc_write, pc_write_cond, i_or_d, mem_read,
                     mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op};

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .write_ir(write_ir), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (state_o !== e.st || act_ov !== e.ov) begin
                n_fails++;
                $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                         e.tag, state_o, act_ov, e.st, e.ov);
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                       input state_t st, input logic [16:0] ov,
                       input string tag);
        exp_t e;
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        e.st  = st;
        e.ov  = ov;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, OP_LW, S_RESET, E_ZERO, "reset_hold");
        cyc(1'b0, 1'b1, OP_LW, S_RESET, E_ZERO, "reset_release");

        // lw with 3 fetch waits and 2 read waits: 10 cycles
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, OP_LW, S_FETCH, E_FETCH_W, "lw_fetch_wait");
        cyc(1'b0, 1'b1, OP_LW, S_FETCH,    E_FETCH_R, "lw_fetch");
        cyc(1'b0, 1'b0, OP_LW, S_DECODE,   E_DECODE,  "lw_decode");
        cyc(1'b0, 1'b1, OP_LW, S_MEM_ADDR, E_ADDR,    "lw_addr");
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'b0, OP_LW, S_MEM_RD, E_MEM_RD, "lw_rd_wait");
        cyc(1'b0, 1'b1, OP_LW, S_MEM_RD,   E_MEM_RD,  "lw_rd");
        cyc(1'b0, 1'b0, OP_LW, S_MEM_WB,   E_MEM_WB,  "lw_wb");

        // R-type then sw back to back
        cyc(1'b0, 1'b1, OP_RTYPE, S_FETCH,  E_FETCH_R, "r_fetch");
        cyc(1'b0, 1'b1, OP_RTYPE, S_DECODE, E_DECODE,  "r_decode");
        cyc(1'b0, 1'b1, OP_RTYPE, S_R_EXEC, E_R_EXEC,  "r_exec");
        cyc(1'b0, 1'b1, OP_RTYPE, S_R_WB,   E_R_WB,    "r_wb");
        cyc(1'b0, 1'b1, OP_SW, S_FETCH,    E_FETCH_R, "sw_fetch");
        cyc(1'b0, 1'b1, OP_SW, S_DECODE,   E_DECODE,  "sw_decode");
        cyc(1'b0, 1'b1, OP_SW, S_MEM_ADDR, E_ADDR,    "sw_addr");
        cyc(1'b0, 1'b1, OP_SW, S_MEM_WR,   E_MEM_WR,  "sw_wr");

        // beq, j, addi
        cyc(1'b0, 1'b1, OP_BEQ, S_FETCH,  E_FETCH_R, "beq_fetch");
        cyc(1'b0, 1'b1, OP_BEQ, S_DECODE, E_DECODE,  "beq_decode");
        cyc(1'b0, 1'b1, OP_BEQ, S_BRANCH, E_BRANCH,  "beq_branch");
        cyc(1'b0, 1'b1, OP_J, S_FETCH,  E_FETCH_R, "j_fetch");
        cyc(1'b0, 1'b1, OP_J, S_DECODE, E_DECODE,  "j_decode");
        cyc(1'b0, 1'b1, OP_J, S_JUMP,   E_JUMP,    "j_jump");
        cyc(1'b0, 1'b1, OP_ADDI, S_FETCH,     E_FETCH_R, "addi_fetch");
        cyc(1'b0, 1'b1, OP_ADDI, S_DECODE,    E_DECODE,  "addi_decode");
        cyc(1'b0, 1'b1, OP_ADDI, S_ADDI_EXEC, E_ADDR,    "addi_exec");
        cyc(1'b0, 1'b1, OP_ADDI, S_ADDI_WB,   E_ADDI_WB, "addi_wb");

        // reset asserted while a data read is pending
        cyc(1'b0, 1'b1, OP_LW, S_FETCH,    E_FETCH_R, "rst_fetch");
        cyc(1'b0, 1'b1, OP_LW, S_DECODE,   E_DECODE,  "rst_decode");
        cyc(1'b0, 1'b1, OP_LW, S_MEM_ADDR, E_ADDR,    "rst_addr");
        cyc(1'b0, 1'b0, OP_LW, S_MEM_RD,   E_MEM_RD,  "rst_rd_wait");
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_o), 32'(S_RESET));
        chk("async_rst_outs",  32'(act_ov),  32'(E_ZERO));
        e.st  = S_RESET;
        e.ov  = E_ZERO;
        e.tag = "rst_mid_rd";
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, OP_LW, S_RESET, E_ZERO,    "rst_after");
        cyc(1'b0, 1'b0, OP_LW, S_FETCH, E_FETCH_W, "rst_refetch");

        // unknown opcode locks up until reset
        cyc(1'b0, 1'b1, 6'b111111, S_FETCH,  E_FETCH_R, "ill_fetch");
        cyc(1'b0, 1'b1, 6'b111111, S_DECODE, E_DECODE,  "ill_decode");
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b1, 6'b111111, S_ILLEGAL, E_ILL, "ill_hold");
        cyc(1'b1, 1'b1, OP_LW, S_RESET, E_ZERO, "ill_reset");
        cyc(1'b0, 1'b1, OP_LW, S_RESET, E_ZERO, "ill_release");
        cyc(1'b0, 1'b1, OP_LW, S_FETCH, E_FETCH_R, "ill_refetch");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
